coin_acceptor: RTL

- Front-end stage directly upstream of the vending controller.
- Synchronises and debounces the three raw coin-sensor lines and rejects invalid or ill-timed insertions.
- Delivers clean, mutually exclusive, single-cycle `nickel`/`dime`/`quarter` pulses that connect straight to the controller's coin inputs.
- Also keeps a saturating count of accepted coins for service diagnostics.

---
 rtl/coin_acceptor_if.sv | 25 ++
 rtl/coin_acceptor.sv | 107 ++++++++++
 2 files changed

// File: rtl/coin_acceptor_if.sv
// Coin-sensor front-end bus: raw sensor lines and busy in, clean coin pulses and count out.
interface coin_acceptor_if;
  localparam int unsigned SENSE_W = 3;
  localparam int unsigned COUNT_W = 8;

  logic [SENSE_W-1:0] coin_sense;
  logic               busy;
  logic               nickel;
  logic               dime;
  logic               quarter;
  logic               reject;
  logic [COUNT_W-1:0] coin_count;

  // Sensor/controller side.
  modport master (
    output coin_sense, busy,
    input  nickel, dime, quarter, reject, coin_count
  );

  // Acceptor side.
  modport slave (
    input  coin_sense, busy,
    output nickel, dime, quarter, reject, coin_count
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronises and debounces three coin-sensor lines, emits one-cycle
// mutually exclusive coin/reject pulses and keeps a saturating accepted-coin count.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic           clk,
  input  logic           rst,
  coin_acceptor_if.slave bus
);
  localparam int unsigned SENSE_W = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned COUNT_W = 8;

  localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    EMIT,
    RELEASE
  } state_t;

  state_t             state;
  logic [SENSE_W-1:0] s1;
  logic [SENSE_W-1:0] s2;
  logic [SENSE_W-1:0] code;
  logic [CNT_W-1:0]   cnt;

  // Two-flop synchroniser plus the debounce/emit/release machine with registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1             <= '0;
      s2             <= '0;
      state          <= IDLE;
      code           <= '0;
      cnt            <= '0;
      bus.nickel     <= 1'b0;
      bus.dime       <= 1'b0;
      bus.quarter    <= 1'b0;
      bus.reject     <= 1'b0;
      bus.coin_count <= '0;
    end else begin
      s1          <= bus.coin_sense;
      s2          <= s1;
      // Pulses are single-cycle: cleared unless set on the decision edge below.
      bus.nickel  <= 1'b0;
      bus.dime    <= 1'b0;
      bus.quarter <= 1'b0;
      bus.reject  <= 1'b0;

      case (state)
        IDLE: begin
          if (s2 != '0) begin
            code  <= s2;
            cnt   <= CNT_W'(1);
            state <= DEBOUNCE;
          end
        end

        DEBOUNCE: begin
          if (s2 != code) begin
            // Pattern changed before it was stable long enough: drop it silently.
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state <= EMIT;
            // busy is looked at only here; the decision is frozen into the pulse registers.
            if ($onehot(code) && !bus.busy) begin
              bus.nickel  <= code[0];
              bus.dime    <= code[1];
              bus.quarter <= code[2];
              if (bus.coin_count != COUNT_MAX) begin
                bus.coin_count <= bus.coin_count + COUNT_W'(1);
              end
            end else begin
              bus.reject <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        EMIT: begin
          state <= RELEASE;
          cnt   <= '0;
        end

        RELEASE: begin
          // Any nonzero sample, same coin or not, restarts the quiet-gap count.
          if (s2 == '0) begin
            if (cnt == GAP_LAST) begin
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
